bla_subtractor_pipe: RTL and testbench
======================================

// Module: bla_subtractor_pipe
// PURPOSE
//  Pipelined borrow-lookahead subtractor: computes {borrow_out, diff} = a - b - borrow_in.
//  It is the subtraction counterpart to the datapath's carry-lookahead adder.
//  Operands are split into GROUP-bit borrow-lookahead groups, with one group resolved per stage.
//  The borrow ripples between stages through a register.
//  Valid/ready streaming on both sides; sits between operand FIFO and result consumer in the ALU path.
// PARAMETERS
//  WIDTH  16  operand width; must be a multiple of GROUP
//  GROUP  4   bits resolved per stage (fixed by package constant; not overridable per instance)
//  NSTAGES = WIDTH/GROUP (localparam, default 4) = pipeline depth
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands valid
//  in_ready   out  1        block can accept operands this cycle
//  a          in   WIDTH    minuend (unsigned)
//  b          in   WIDTH    subtrahend (unsigned)
//  borrow_in  in   1        incoming borrow (chaining)
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  diff_out   out  WIDTH+1  {borrow_out, diff}; borrow_out=1 iff a < b+borrow_in
//  ovf        out  1        signed overflow (only with BLA_SUB_SIGNED_OVF_EN)
// BEHAVIOUR
//  - Per group: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ bin_i; bout_i = g_i | (p_i & bin_i).
//  - Lookahead is flattened within a group, with no ripple inside a group.
//  - Stage k resolves group k (LSB group in stage 1).
//  - Stage k registers: valid_k; diff bits [k*GROUP-1:0]; borrow into group k; unprocessed a/b upper bits (skew).
//  - Latency: operands accepted at edge t -> out_valid=1 after edge t+NSTAGES (4 cycles at default).
//  - Global advance = !out_valid | out_ready. When advance=1, all stages shift; when 0, all hold.
//  - in_ready = advance (combinational). A transfer occurs only when in_valid & in_ready.
//  - A bubble is inserted as valid=0 when in_valid=0 and advance=1.
//  - Output held stable (diff_out, ovf, out_valid) while out_valid & !out_ready.
//  - Throughput 1 result/cycle with out_ready=1. Order strictly preserved; no drops, no duplicates.
//  - Borrow wraps modulo 2^WIDTH: 0x0000-0x0001 -> diff 0xFFFF, borrow_out 1.
//  - Reset: every valid_k=0, out_valid=0, diff_out=0, ovf=0 on the edge rst is sampled high.
//  - Reset mid-operation: in-flight operations are discarded, not completed.
//  - in_ready=1 in the first cycle after reset deasserts.
//  - rst has priority over any simultaneous transfer.
//  - No FSM: control is the valid shift chain only.
// CONFIGURATION
//  `BLA_SUB_SIGNED_OVF_EN` defined:
//   - ovf = (a[MSB]^b[MSB]) & (diff[MSB]^a[MSB]), treating a and b as two's complement.
//   - ovf is aligned and registered with diff_out, and held/reset identically.
//   - a[MSB] and b[MSB] are carried through the skew registers.
//  Not defined: ovf tied to 1'b0; no extra registers.
// STRUCTURE
//  Package bla_pkg:
//   - localparam BLA_GROUP=4
//   - typedef grp_t (logic [BLA_GROUP-1:0])
//   - function bla_group_f(a,b,bin) -> {bout,d}, a reference model reused by the bench
//  Sub-module bla_group (combinational, GROUP-bit lookahead cell):
//   - one instance per stage via generate loop
//   - top level holds only the stage registers and the advance/valid logic
// TESTING (WIDTH=16, out_ready=1 unless stated)
//  1. a=0x1234,b=0x0234,bin=0 accepted at cycle 0
//     -> out_valid at cycle 4, diff_out=0x0_1000.
//  2. a=0x0000,b=0x0001,bin=0 -> diff_out=0x1_FFFF (borrow crosses all 4 stages).
//  3. a=0x0005,b=0x0005,bin=1 -> diff_out=0x1_FFFF; a=0x0005,b=0x0005,bin=0 -> 0x0_0000.
//  4. 8 back-to-back ops; out_ready=0 for cycles 6-8:
//     - in_ready=0 during the stall
//     - output held stable
//     - all 8 results in order, matching bla_group_f chained model
//     - total 8+3+4 cycles.
//  5. rst=1 at cycle 2 with 2 ops in flight
//     -> out_valid=0, diff_out=0 from cycle 3; no stale result ever appears.
//  6. (OVF_EN) a=0x8000,b=0x0001 -> diff_out=0x0_7FFF, ovf=1;
//     a=0x7FFF,b=0xFFFF -> 0x1_8000, ovf=1; a=0x0003,b=0x0001 -> ovf=0.

Source files
------------

// File: rtl/bla_pkg.sv
// Shared definitions for the borrow-lookahead subtractor.
//   BLA_GROUP   : bits resolved per pipeline stage (fixed, not per instance)
//   grp_t       : one lookahead group of operand bits
//   bla_group_f : bit-serial behavioural model of one group, returns {bout, d}
package bla_pkg;

    localparam int unsigned BLA_GROUP = 4;

    typedef logic [BLA_GROUP-1:0] grp_t;

    function automatic logic [BLA_GROUP:0] bla_group_f(
        input grp_t a,
        input grp_t b,
        input logic bin
    );
        logic [BLA_GROUP:0] r;
        logic               c;
        r = '0;
        c = bin;
        for (int unsigned i = 0; i < BLA_GROUP; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & c);
        end
        r[BLA_GROUP] = c;
        return r;
    endfunction

endpackage

// File: rtl/bla_group.sv
// Combinational GROUP-bit borrow-lookahead cell.
//   a, b : group operand bits (minuend, subtrahend)
//   bin  : borrow into the group LSB
//   d    : difference bits
//   bout : borrow out of the group MSB
module bla_group
    import bla_pkg::*;
(
    input  grp_t a,
    input  grp_t b,
    input  logic bin,
    output grp_t d,
    output logic bout
);

    grp_t               g;
    grp_t               p;
    logic [BLA_GROUP:0] brw;
    logic               term;

    always_comb begin
        g    = ~a & b;
        p    = ~(a ^ b);
        brw  = '0;
        term = 1'b0;
        // Borrow into bit j as a flat sum of products: bin propagated through
        // every lower bit, or a generate at bit i propagated through i+1..j-1.
        for (int unsigned j = 0; j <= BLA_GROUP; j++) begin
            term = bin;
            for (int unsigned i = 0; i < j; i++) term = term & p[i];
            brw[j] = term;
            for (int unsigned i = 0; i < j; i++) begin
                term = g[i];
                for (int unsigned m = i + 1; m < j; m++) term = term & p[m];
                brw[j] = brw[j] | term;
            end
        end
    end

    assign d    = a ^ b ^ brw[BLA_GROUP-1:0];
    assign bout = brw[BLA_GROUP];

endmodule

// File: rtl/bla_subtractor_pipe.sv
// Pipelined borrow-lookahead subtractor: {borrow_out, diff} = a - b - borrow_in.
// One lookahead group is resolved per stage, borrow registered between stages.
// Optional feature macro: BLA_SUB_SIGNED_OVF_EN (signed overflow flag on ovf).
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready is combinational)
//   a, b, borrow_in      : minuend, subtrahend, incoming borrow
//   out_valid / out_ready: result handshake
//   diff_out             : {borrow_out, diff}
//   ovf                  : two's complement overflow (0 when feature disabled)
module bla_subtractor_pipe
    import bla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   diff_out,
    output logic             ovf
);

    localparam int unsigned GROUP   = BLA_GROUP;
    localparam int unsigned NSTAGES = WIDTH / GROUP;

    // Rank 0 captures the operands; rank k (1..NSTAGES) holds the result of
    // group k-1. Unprocessed operand bits are kept right-aligned so every
    // stage reads its group from bits [GROUP-1:0]; resolved difference bits
    // shift in from the top so the last rank holds the full difference.
    logic             valid [NSTAGES+1];
    logic             brw   [NSTAGES+1];
    logic [WIDTH-1:0] dacc  [NSTAGES+1];
    logic [WIDTH-1:0] a_sh  [NSTAGES];
    logic [WIDTH-1:0] b_sh  [NSTAGES];
    grp_t             gd    [NSTAGES];
    logic             gbo   [NSTAGES];
    logic             advance;

    assign advance  = !valid[NSTAGES] | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        bla_group u_grp (
            .a    (a_sh[k][GROUP-1:0]),
            .b    (b_sh[k][GROUP-1:0]),
            .bin  (brw[k]),
            .d    (gd[k]),
            .bout (gbo[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s <= NSTAGES; s++) begin
                valid[s] <= 1'b0;
                brw[s]   <= 1'b0;
                dacc[s]  <= '0;
            end
            for (int unsigned s = 0; s < NSTAGES; s++) begin
                a_sh[s] <= '0;
                b_sh[s] <= '0;
            end
        end else if (advance) begin
            valid[0] <= in_valid;
            brw[0]   <= borrow_in;
            dacc[0]  <= '0;
            a_sh[0]  <= a;
            b_sh[0]  <= b;
            for (int unsigned s = 1; s <= NSTAGES; s++) begin
                valid[s] <= valid[s-1];
                brw[s]   <= gbo[s-1];
                dacc[s]  <= {gd[s-1], dacc[s-1][WIDTH-1:GROUP]};
            end
            for (int unsigned s = 1; s < NSTAGES; s++) begin
                a_sh[s] <= a_sh[s-1] >> GROUP;
                b_sh[s] <= b_sh[s-1] >> GROUP;
            end
        end
    end

    assign out_valid = valid[NSTAGES];
    assign diff_out  = {brw[NSTAGES], dacc[NSTAGES]};

`ifdef BLA_SUB_SIGNED_OVF_EN
    // The operand MSBs reach bit GROUP-1 of the last skew rank together with
    // the final group, so the flag is formed there and lands with diff_out.
    logic ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (advance) begin
            ovf_r <= (a_sh[NSTAGES-1][GROUP-1] ^ b_sh[NSTAGES-1][GROUP-1])
                   & (gd[NSTAGES-1][GROUP-1] ^ a_sh[NSTAGES-1][GROUP-1]);
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bla_subtractor_pipe.sv
// Self-checking bench for bla_subtractor_pipe (WIDTH=16).
module tb_bla_subtractor_pipe;
    import bla_pkg::*;

`ifdef BLA_SUB_SIGNED_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        borrow_in;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] diff_out;
    logic        ovf;

    typedef struct packed {
        logic [16:0] d;
        logic        o;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   pops = 0;
    int   last_pop_cyc = 0;

    bla_subtractor_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_out  (diff_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Plain integer arithmetic reference.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        exp_t e;
        int   sd;
        e.d = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
        sd  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        e.o = OVF_ON && (sd > 32767 || sd < -32768);
        return e;
    endfunction

    function automatic logic [16:0] chain_f(input logic [15:0] ca, input logic [15:0] cb, input logic cbin);
        logic [4:0]  r;
        logic [15:0] d;
        logic        c;
        c = cbin;
        d = '0;
        for (int unsigned g = 0; g < 4; g++) begin
            r           = bla_group_f(ca[g*4 +: 4], cb[g*4 +: 4], c);
            d[g*4 +: 4] = r[3:0];
            c           = r[4];
        end
        return {c, d};
    endfunction

    // Scoreboard: compares every valid output against the queue head and
    // checks the ready relation; held outputs are re-checked every cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check("diff_out", 32'(diff_out), 32'(q[0].d));
                    check("ovf", 32'(ovf), 32'(q[0].o));
                    if (out_ready) begin
                        void'(q.pop_front());
                        pops++;
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, borrow_in));
        end
    end

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) break;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                input logic tbin, input logic [16:0] exp_d, input logic exp_o);
        a         = ta;
        b         = tb;
        borrow_in = tbin;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 check({tag, "_early"}, 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff_out), 32'(exp_d));
        check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        oc [8];
        int          c0;
        int          base;
        exp_t        e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_diff", 32'(diff_out), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        #1 check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors with exact latency.
        run_directed("t1", 16'h1234, 16'h0234, 1'b0, 17'h0_1000, 1'b0);
        run_directed("t2", 16'h0000, 16'h0001, 1'b0, 17'h1_FFFF, 1'b0);
        run_directed("t3a", 16'h0005, 16'h0005, 1'b1, 17'h1_FFFF, 1'b0);
        run_directed("t3b", 16'h0005, 16'h0005, 1'b0, 17'h0_0000, 1'b0);
        run_directed("t6a", 16'h8000, 16'h0001, 1'b0, 17'h0_7FFF, OVF_ON);
        run_directed("t6b", 16'h7FFF, 16'hFFFF, 1'b0, 17'h1_8000, OVF_ON);
        run_directed("t6c", 16'h0003, 16'h0001, 1'b0, 17'h0_0002, 1'b0);
        drain();

        // Eight back-to-back operations with a three-cycle output stall.
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 1'($urandom);
            e = model(oa[i], ob[i], oc[i]);
            check("pkg_chain", 32'(chain_f(oa[i], ob[i], oc[i])), 32'(e.d));
        end
        a = oa[0]; b = ob[0]; borrow_in = oc[0]; in_valid = 1'b1;
        @(posedge clk);
        #1;
        c0   = cyc;
        base = pops;
        fork
            begin
                for (int i = 1; i < 8; i++) begin
                    a = oa[i]; b = ob[i]; borrow_in = oc[i];
                    wait_accept();
                    #1;
                end
                in_valid = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t4_stall_rdy", 32'(in_ready), 32'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (pops - base >= 8) break;
        end
        check("t4_count", 32'(pops - base), 32'd8);
        check("t4_cycles", 32'(last_pop_cyc - c0 + 1), 32'd15);
        drain();

        // Reset with two operations in flight; a transfer offered during the
        // reset cycle must be ignored.
        a = 16'h4321; b = 16'h1111; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 16'h0000; b = 16'h0001;
        @(posedge clk);
        #1 rst = 1'b1; a = 16'h00FF; b = 16'h000F;
        @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff_out), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (8) begin
            @(posedge clk);
            #1 check("rst_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            borrow_in = 1'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 16'h0000;
                1:       a = 16'hFFFF;
                2:       a = 16'h8000;
                3:       a = 16'h7FFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 16'h0000;
                1:       b = 16'hFFFF;
                2:       b = 16'h8000;
                3:       b = 16'h7FFF;
                default: b = 16'($urandom);
            endcase
            @(posedge clk);
            #1;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
